// File: rtl/adc_frame_ctrl.sv
// adc_frame_ctrl: capture sequencer that decimates ADC strobes, optionally waits for a
// rising-edge level trigger, fills one FFT input frame, starts the FFT and counts overruns.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   enable            level-sensitive run request
//   decim             keep one accepted strobe in every decim+1
//   trig_level        rising-edge trigger threshold (trigger build only)
//   sample_valid/data ADC sample strobe and 12-bit unsigned data
//   buf_we/addr/data  registered FFT buffer write port
//   fft_start/done    FFT handshake pulses
//   frame_peak        maximum sample of the last completed frame
//   overrun_cnt       saturating count of strobes seen while the FFT runs
//   state             IDLE=0, ARM=1, FILL=2, PROCESS=3
// Build option: define ADC_FRAME_TRIGGER_EN to include the ARM state and level trigger.
module adc_frame_ctrl #(
    parameter int FRAME_LEN = 256,
    parameter int ADDR_W    = 8,
    parameter int DECIM_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [DECIM_W-1:0] decim,
    input  logic [11:0]        trig_level,
    input  logic               sample_valid,
    input  logic [11:0]        sample_data,
    output logic               buf_we,
    output logic [ADDR_W-1:0]  buf_addr,
    output logic [11:0]        buf_data,
    output logic               fft_start,
    input  logic               fft_done,
    output logic [11:0]        frame_peak,
    output logic [7:0]         overrun_cnt,
    output logic [1:0]         state
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, FILL = 2'd2, PROC = 2'd3} state_t;

    state_t             state_q;
    logic               we_q, start_q;
    logic [ADDR_W-1:0]  buf_addr_q, addr_q;
    logic [11:0]        buf_data_q, peak_q, max_q, max_d;
    logic [7:0]         ovr_q;
    logic [DECIM_W-1:0] dec_q, dec_d;
    logic               accept, restart, last;

`ifdef ADC_FRAME_TRIGGER_EN
    localparam state_t ENTRY = ARM;
    logic [11:0] prev_q;
    logic        trig;
    assign trig = prev_q < trig_level && sample_data >= trig_level;
`else
    localparam state_t ENTRY = FILL;
    logic unused_trig;
    assign unused_trig = ^trig_level;
`endif

    // decim is read live, so a shrinking decim must still wrap the counter
    assign dec_d   = (dec_q >= decim) ? '0 : dec_q + 1'b1;
    assign accept  = sample_valid && dec_q == '0;
    // strobes in the same cycle as a restart are never accepted
    assign restart = enable && (state_q == IDLE || (state_q == PROC && fft_done));
    assign max_d   = (sample_data > max_q) ? sample_data : max_q;
    assign last    = addr_q == ADDR_W'(FRAME_LEN - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            start_q    <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            peak_q     <= '0;
            ovr_q      <= '0;
            dec_q      <= '0;
            addr_q     <= '0;
            max_q      <= '0;
`ifdef ADC_FRAME_TRIGGER_EN
            prev_q     <= 12'hFFF;
`endif
        end else begin
            we_q    <= 1'b0;
            start_q <= 1'b0;
            if (state_q == PROC && sample_valid && ovr_q != 8'hFF)
                ovr_q <= ovr_q + 1'b1;
            if (restart) begin
                state_q <= ENTRY;
                addr_q  <= '0;
                max_q   <= '0;
                dec_q   <= '0;
`ifdef ADC_FRAME_TRIGGER_EN
                prev_q  <= 12'hFFF;
`endif
            end else begin
                case (state_q)
                    PROC: if (fft_done) state_q <= IDLE;
`ifdef ADC_FRAME_TRIGGER_EN
                    ARM: begin
                        if (!enable) state_q <= IDLE;
                        else if (sample_valid) begin
                            dec_q <= dec_d;
                            if (accept) begin
                                prev_q <= sample_data;
                                if (trig) begin
                                    we_q       <= 1'b1;
                                    buf_addr_q <= '0;
                                    buf_data_q <= sample_data;
                                    addr_q     <= ADDR_W'(1);
                                    max_q      <= sample_data;
                                    dec_q      <= '0;
                                    state_q    <= FILL;
                                end
                            end
                        end
                    end
`endif
                    FILL: begin
                        if (!enable) state_q <= IDLE;
                        else if (sample_valid) begin
                            dec_q <= dec_d;
                            if (accept) begin
                                we_q       <= 1'b1;
                                buf_addr_q <= addr_q;
                                buf_data_q <= sample_data;
                                max_q      <= max_d;
                                if (last) begin
                                    state_q <= PROC;
                                    start_q <= 1'b1;
                                    peak_q  <= max_d;
                                end else addr_q <= addr_q + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign buf_we      = we_q;
    assign buf_addr    = buf_addr_q;
    assign buf_data    = buf_data_q;
    assign fft_start   = start_q;
    assign frame_peak  = peak_q;
    assign overrun_cnt = ovr_q;
    assign state       = state_q;
endmodule

// File: tb/tb_adc_frame_ctrl.sv
// tb_adc_frame_ctrl: table-driven and directed checks of adc_frame_ctrl with FRAME_LEN=8.
module tb_adc_frame_ctrl;
    logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, sample_valid = 1'b0, fft_done = 1'b0;
    logic [3:0]  decim = '0;
    logic [11:0] trig_level = 12'h800, sample_data = '0;
    logic        buf_we, fft_start;
    logic [2:0]  buf_addr;
    logic [11:0] buf_data, frame_peak;
    logic [7:0]  overrun_cnt;
    logic [1:0]  state;

    adc_frame_ctrl #(.FRAME_LEN(8), .ADDR_W(3), .DECIM_W(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .decim(decim), .trig_level(trig_level),
        .sample_valid(sample_valid), .sample_data(sample_data), .buf_we(buf_we),
        .buf_addr(buf_addr), .buf_data(buf_data), .fft_start(fft_start), .fft_done(fft_done),
        .frame_peak(frame_peak), .overrun_cnt(overrun_cnt), .state(state)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0;

    typedef struct {
        int          gap;
        int          en, dc, sv, d, fd;
        logic [38:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [38:0] pk(int we, int a, int bd, int st, int s, int p, int o);
        return {we[0], a[2:0], bd[11:0], st[0], s[1:0], p[11:0], o[7:0]};
    endfunction

    function automatic vec_t mk(int gap, int en, int dc, int sv, int d, int fd, logic [38:0] e);
        vec_t v;
        v.gap = gap; v.en = en; v.dc = dc; v.sv = sv; v.d = d; v.fd = fd; v.exp = e;
        return v;
    endfunction

    task automatic cyc(input int en, input int dc, input int sv, input int d, input int fd);
        @(negedge clk);
        enable = en[0]; decim = dc[3:0]; sample_valid = sv[0]; sample_data = d[11:0]; fft_done = fd[0];
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [38:0] e);
        logic [38:0] a;
        a = pk(buf_we, buf_addr, buf_data, fft_start, state, frame_peak, overrun_cnt);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got we=%0d addr=%0d data=%h start=%0d state=%0d peak=%h ovr=%0d, expected we=%0d addr=%0d data=%h start=%0d state=%0d peak=%h ovr=%0d",
                     nm, a[38], a[37:35], a[34:23], a[22], a[21:20], a[19:8], a[7:0],
                     e[38], e[37:35], e[34:23], e[22], e[21:20], e[19:8], e[7:0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("reset", '0);
        reset = 1'b0;
`ifdef ADC_FRAME_TRIGGER_EN
        cyc(1, 0, 0, 0, 0);
        chk("arm_entry", pk(0, 0, 0, 0, 1, 0, 0));
        cyc(1, 0, 1, 'h900, 0);
        chk("above_no_trig", pk(0, 0, 0, 0, 1, 0, 0));
        cyc(1, 0, 1, 'h100, 0);
        chk("low_no_trig", pk(0, 0, 0, 0, 1, 0, 0));
        cyc(1, 0, 1, 'h7FF, 0);
        chk("below_no_trig", pk(0, 0, 0, 0, 1, 0, 0));
        cyc(1, 0, 1, 'h800, 0);
        chk("trigger", pk(1, 0, 'h800, 0, 2, 0, 0));
        for (int k = 1; k < 8; k++) begin
            cyc(1, 0, 1, 'h10 * k, 0);
            chk($sformatf("trig_fill%0d", k), pk(1, k, 'h10 * k, k == 7, k == 7 ? 3 : 2, k == 7 ? 'h800 : 0, 0));
        end
        cyc(1, 0, 0, 0, 1);
        chk("rearm", pk(0, 7, 'h70, 0, 1, 'h800, 0));
`else
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, pk(0, 0, 0, 0, 2, 0, 0)));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(15, 1, 0, 1, k, 0, pk(1, k - 1, k, k == 8, k == 8 ? 3 : 2, k == 8 ? 8 : 0, 0)));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, pk(0, 7, 8, 0, 3, 8, 0)));
        for (int k = 1; k <= 5; k++)
            tbl.push_back(mk(0, 1, 0, 1, 'h055, 0, pk(0, 7, 8, 0, 3, 8, k)));
        tbl.push_back(mk(0, 1, 0, 1, 'h077, 1, pk(0, 7, 8, 0, 2, 8, 6)));
        for (int i = 0; i < 24; i++)
            tbl.push_back(mk(0, 1, 2, 1, i, 0, pk(i % 3 == 0, i / 3, (i / 3) * 3, i == 21,
                             i >= 21 ? 3 : 2, i >= 21 ? 21 : 8, i < 22 ? 6 : i - 15)));
        for (int i = 0; i < tbl.size(); i++) begin
            repeat (tbl[i].gap) cyc(tbl[i].en, tbl[i].dc, 0, 0, 0);
            cyc(tbl[i].en, tbl[i].dc, tbl[i].sv, tbl[i].d, tbl[i].fd);
            chk($sformatf("vec%0d", i), tbl[i].exp);
        end
        repeat (300) cyc(1, 2, 1, 'h0AA, 0);
        chk("ovr_saturate", pk(0, 7, 21, 0, 3, 21, 255));
        cyc(0, 0, 0, 0, 1);
        chk("done_to_idle", pk(0, 7, 21, 0, 0, 21, 255));
        cyc(1, 0, 0, 0, 0);
        chk("idle_to_fill", pk(0, 7, 21, 0, 2, 21, 255));
        for (int k = 0; k < 5; k++) begin
            cyc(1, 0, 1, 'h100 + k, 0);
            chk($sformatf("abort_fill%0d", k), pk(1, k, 'h100 + k, 0, 2, 21, 255));
        end
        cyc(1, 0, 0, 0, 1);
        chk("done_outside_proc", pk(0, 4, 'h104, 0, 2, 21, 255));
        cyc(0, 0, 1, 'hFFF, 0);
        chk("abort", pk(0, 4, 'h104, 0, 0, 21, 255));
        cyc(0, 0, 0, 0, 0);
        chk("abort_quiet", pk(0, 4, 'h104, 0, 0, 21, 255));
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            cyc(1, 0, 1, 'h200 + k, 0);
            chk($sformatf("rst_fill%0d", k), pk(1, k, 'h200 + k, 0, 2, 21, 255));
        end
        reset = 1'b1;
        cyc(1, 0, 1, 'h3FF, 0);
        chk("mid_reset", '0);
        reset = 1'b0;
        cyc(1, 0, 0, 0, 0);
        chk("post_reset_fill", pk(0, 0, 0, 0, 2, 0, 0));
        cyc(1, 0, 1, 'h321, 0);
        chk("post_reset_first", pk(1, 0, 'h321, 0, 2, 0, 0));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
